dxm_sync_filt: RTL and testbench
================================

// Module: dxm_sync_filt
// PURPOSE
//  Parametrised multi-bit flop pipeline: N-stage synchroniser chain, optional
//  debounce/stability filter and per-bit edge-pulse outputs. Used for TRNG
//  control/status crossings, external level inputs and debounced enables.
//  Generalises the single-bit reset flop to any width, stage count and filter
//  length.
// PARAMETERS
//  WIDTH    1  bus width in bits (>=1)
//  STAGES   2  synchroniser flops before the filter (2..4)
//  FILT     0  stability length in enabled cycles; 0 = filter bypassed (0..255)
//  RST_VAL  0  reset value of every bit of q, chain and candidate (0 or 1)
// PORTS
//  clk     in   1      clock; every flop is on its rising edge
//  rst     in   1      reset, synchronous, active-high
//  en      in   1      advance enable; 0 freezes all state
//  d       in   WIDTH  asynchronous or foreign-domain input bus
//  q       out  WIDTH  synchronised, filtered level
//  q_rise  out  WIDTH  1-cycle pulse per bit, cycle q[i] goes 0->1
//  q_fall  out  WIDTH  1-cycle pulse per bit, cycle q[i] goes 1->0
//  q_chg   out  1      OR-reduction of q_rise|q_fall (registered, aligned)
// BEHAVIOUR
//  Clocking and reset: one clock; reset is synchronous and active-high.
//  - rst=1 at an edge: sync[*], cand, q <= {WIDTH{RST_VAL}}; cnt <= 0;
//    q_rise/q_fall/q_chg <= 0. rst overrides en. Reset never produces pulses.
//  - en=0: sync, cand, cnt, q hold; q_rise/q_fall/q_chg <= 0 at that edge.
//  - Chain (en=1): sync[0]<=d; sync[k]<=sync[k-1]; sync_out = sync[STAGES-1].
//  - FILT=0: q <= sync_out each enabled edge. Latency d->q = STAGES+1 edges.
//  - FILT>=1: cand (WIDTH) and cnt ($clog2(FILT+1) bits) per enabled edge:
//      sync_out != cand      : cand <= sync_out; cnt <= 1
//      sync_out == cand      : cnt <= (cnt==FILT) ? FILT : cnt+1  (saturate)
//      pre-edge cnt==FILT and cand != q : q <= cand
//    Latency d->q = STAGES+FILT+1 enabled edges for a held input.
//  - Filter is bus-level: a change on any bit restarts cnt for whole bus; no
//    partial-bus updates of q ever occur.
//  - Input shorter than FILT consecutive stable sync_out cycles is discarded;
//    q never changes. A glitch returning to q's value restarts cnt, no pulse.
//  - Pulses: at the edge q updates, q_rise <= q_next & ~q, q_fall <= ~q_next &
//    q, q_chg <= |(q_next ^ q); else all 0. Pulses are coincident with new q
//    value, exactly one cycle wide; back-to-back updates give back-to-back
//    pulses.
//  - cnt saturation: cnt never wraps; stays FILT while input stable.
//  - Reset mid-filter: pending cand discarded, q returns to RST_VAL with no
//    pulse; next change restarts from cnt=0.
//  - Outputs are registered only; no combinational path d->outputs.
// TESTING
//  1 WIDTH=1,STAGES=2,FILT=0: rst 3 cyc, d 0->1 at edge 0 -> q=1 and
//    q_rise=1 for one cycle after edge 3; q_chg=1 same cycle.
//  2 WIDTH=4,STAGES=3,FILT=4: d=4'hA held -> q=4'hA after edge 8 exactly;
//    q_rise=4'hA, q_fall=0 one cycle; q stays A, cnt saturates at 4.
//  3 FILT=4: d pulses 4'h1 for 3 cycles then back to 0 -> q stays 0, no
//    pulses; repeat with 4-cycle pulse -> q=1 then q=0, q_rise then q_fall.
//  4 en toggled 0 for 5 cycles mid-filter (cnt=2) -> q, cnt frozen; after en=1
//    q updates after remaining 2 enabled stable edges+1; pulses 0 while en=0.
//  5 RST_VAL=1, rst asserted while cnt=3 toward value 0 -> q=all-ones, no
//    q_fall, cnt=0; rst overrides en=1 and d changes on same edge.
//  6 WIDTH=8,FILT=2: bit0 changes, bit7 changes 1 cycle later -> cnt restarts,
//    q updates once with both bits, q_chg single pulse.

Source files
------------

// File: rtl/dxm_sync_filt.sv
// Multi-bit synchroniser chain with an optional bus-level stability filter
// and registered per-bit edge pulses, all on a single clock.
module dxm_sync_filt #(
    parameter int WIDTH   = 1,
    parameter int STAGES  = 2,
    parameter int FILT    = 0,
    parameter int RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_rise,
    output logic [WIDTH-1:0] q_fall,
    output logic             q_chg
);
    localparam int              CW       = (FILT > 0) ? $clog2(FILT + 1) : 1;
    localparam logic [CW-1:0]   FILT_C   = CW'(FILT);
    localparam logic [CW-1:0]   ONE_C    = CW'(1);
    localparam logic            RST_BIT  = (RST_VAL != 0) ? 1'b1 : 1'b0;
    localparam logic [WIDTH-1:0] RST_WORD = {WIDTH{RST_BIT}};

    logic [STAGES-1:0][WIDTH-1:0] sync_r;
    logic [WIDTH-1:0]             sync_out_s;
    logic [WIDTH-1:0]             q_next_s;

    assign sync_out_s = sync_r[STAGES-1];

    // synchroniser shift chain, newest sample in stage 0
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= {STAGES{RST_WORD}};
        end else if (en) begin
            sync_r <= {sync_r[STAGES-2:0], d};
        end
    end

    if (FILT > 0) begin : g_filt
        logic [WIDTH-1:0] cand_r;
        logic [CW-1:0]    cnt_r;

        // candidate tracking: any bit change restarts the count for the whole bus
        always_ff @(posedge clk) begin
            if (rst) begin
                cand_r <= RST_WORD;
                cnt_r  <= {CW{1'b0}};
            end else if (en) begin
                if (sync_out_s != cand_r) begin
                    cand_r <= sync_out_s;
                    cnt_r  <= ONE_C;
                end else if (cnt_r == FILT_C) begin
                    cnt_r  <= FILT_C;
                end else begin
                    cnt_r  <= cnt_r + ONE_C;
                end
            end
        end

        // promote the candidate once it has been stable for the full length
        always_comb begin
            q_next_s = q;
            if ((cnt_r == FILT_C) && (cand_r != q)) begin
                q_next_s = cand_r;
            end else begin
                q_next_s = q;
            end
        end
    end else begin : g_bypass
        assign q_next_s = sync_out_s;
    end

    // output level and single-cycle edge pulses, all registered
    always_ff @(posedge clk) begin
        if (rst) begin
            q      <= RST_WORD;
            q_rise <= {WIDTH{1'b0}};
            q_fall <= {WIDTH{1'b0}};
            q_chg  <= 1'b0;
        end else if (en) begin
            q      <= q_next_s;
            q_rise <= q_next_s & ~q;
            q_fall <= ~q_next_s & q;
            q_chg  <= |(q_next_s ^ q);
        end else begin
            q_rise <= {WIDTH{1'b0}};
            q_fall <= {WIDTH{1'b0}};
            q_chg  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dxm_sync_filt.sv
// Directed bench for dxm_sync_filt: four parameterisations share clock,
// reset and enable; each scenario drives and checks one instance.
module tb_dxm_sync_filt;
    logic       clk;
    logic       rst;
    logic       en;
    logic [0:0] d1, q1, r1, f1;
    logic       c1;
    logic [3:0] d2, q2, r2, f2;
    logic       c2;
    logic [3:0] d3, q3, r3, f3;
    logic       c3;
    logic [7:0] d4, q4, r4, f4;
    logic       c4;
    int         n_total = 0;
    int         n_bad   = 0;

    dxm_sync_filt #(.WIDTH(1), .STAGES(2), .FILT(0), .RST_VAL(0)) u1 (
        .clk(clk), .rst(rst), .en(en), .d(d1),
        .q(q1), .q_rise(r1), .q_fall(f1), .q_chg(c1));
    dxm_sync_filt #(.WIDTH(4), .STAGES(3), .FILT(4), .RST_VAL(0)) u2 (
        .clk(clk), .rst(rst), .en(en), .d(d2),
        .q(q2), .q_rise(r2), .q_fall(f2), .q_chg(c2));
    dxm_sync_filt #(.WIDTH(4), .STAGES(2), .FILT(4), .RST_VAL(1)) u3 (
        .clk(clk), .rst(rst), .en(en), .d(d3),
        .q(q3), .q_rise(r3), .q_fall(f3), .q_chg(c3));
    dxm_sync_filt #(.WIDTH(8), .STAGES(2), .FILT(2), .RST_VAL(0)) u4 (
        .clk(clk), .rst(rst), .en(en), .d(d4),
        .q(q4), .q_rise(r4), .q_fall(f4), .q_chg(c4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1;
        d1 = 1'b0; d2 = 4'h0; d3 = 4'hF; d4 = 8'h00;
        repeat (3) tick();
        chk("rst_q1", 32'(q1), 32'(1'b0));
        chk("rst_q2", 32'(q2), 32'(4'h0));
        chk("rst_q3", 32'(q3), 32'(4'hF));
        chk("rst_q4", 32'(q4), 32'(8'h00));
        chk("rst_pulse", 32'({c1, c2, c3, c4, r2, f3}), 32'(12'h000));
        rst = 1'b0;

        // bypass filter: latency 3 edges
        d1 = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("t1_q", 32'(q1), 32'(k >= 3));
            chk("t1_rise", 32'(r1), 32'(k == 3));
            chk("t1_chg", 32'(c1), 32'(k == 3));
            chk("t1_fall", 32'(f1), 32'(1'b0));
        end
        d1 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("t1_q_back", 32'(q1), 32'(k < 3));
            chk("t1_fall_back", 32'(f1), 32'(k == 3));
        end
        repeat (12) tick();

        // held value through 3 stages + 4-long filter: q at edge 8
        d2 = 4'hA;
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk("t2_q", 32'(q2), 32'((k >= 8) ? 4'hA : 4'h0));
            chk("t2_rise", 32'(r2), 32'((k == 8) ? 4'hA : 4'h0));
            chk("t2_fall", 32'(f2), 32'(4'h0));
            chk("t2_chg", 32'(c2), 32'(k == 8));
        end
        d2 = 4'h0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("t2_q_back", 32'(q2), 32'((k >= 8) ? 4'h0 : 4'hA));
            chk("t2_fall_back", 32'(f2), 32'((k == 8) ? 4'hA : 4'h0));
        end
        repeat (6) tick();

        // 3-cycle pulse is shorter than the filter and is discarded
        for (int k = 1; k <= 14; k++) begin
            d2 = (k <= 3) ? 4'h1 : 4'h0;
            tick();
            chk("t3_short_q", 32'(q2), 32'(4'h0));
            chk("t3_short_chg", 32'(c2), 32'(1'b0));
        end
        // 4-cycle pulse passes: q=1 after edges 8..11, back to 0 at 12
        for (int k = 1; k <= 14; k++) begin
            d2 = (k <= 4) ? 4'h1 : 4'h0;
            tick();
            chk("t3_long_q", 32'(q2), 32'((k >= 8 && k <= 11) ? 4'h1 : 4'h0));
            chk("t3_long_rise", 32'(r2), 32'((k == 8) ? 4'h1 : 4'h0));
            chk("t3_long_fall", 32'(f2), 32'((k == 12) ? 4'h1 : 4'h0));
        end
        repeat (6) tick();

        // enable dropped for 5 edges with cnt=2: update slips to edge 13
        d2 = 4'h5;
        for (int k = 1; k <= 14; k++) begin
            en = (k >= 6 && k <= 10) ? 1'b0 : 1'b1;
            tick();
            chk("t4_q", 32'(q2), 32'((k >= 13) ? 4'h5 : 4'h0));
            chk("t4_rise", 32'(r2), 32'((k == 13) ? 4'h5 : 4'h0));
            chk("t4_chg", 32'(c2), 32'(k == 13));
        end
        en = 1'b1;

        // reset with cnt=3 pending toward 0 on the all-ones reset instance
        d3 = 4'h0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("t5_pre_q", 32'(q3), 32'(4'hF));
        end
        rst = 1'b1; d3 = 4'h3;
        tick();
        chk("t5_rst_q", 32'(q3), 32'(4'hF));
        chk("t5_rst_fall", 32'(f3), 32'(4'h0));
        chk("t5_rst_chg", 32'(c3), 32'(1'b0));
        chk("t5_rst_q2", 32'(q2), 32'(4'h0));
        chk("t5_rst_f2", 32'(f2), 32'(4'h0));
        chk("t5_rst_c2", 32'(c2), 32'(1'b0));
        rst = 1'b0; d3 = 4'h0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("t5_q", 32'(q3), 32'((k >= 7) ? 4'h0 : 4'hF));
            chk("t5_fall", 32'(f3), 32'((k == 7) ? 4'hF : 4'h0));
        end
        repeat (10) tick();

        // staggered bit changes restart the bus-level count: one update
        for (int k = 1; k <= 8; k++) begin
            d4 = (k == 1) ? 8'h01 : 8'h81;
            tick();
            chk("t6_q", 32'(q4), 32'((k >= 6) ? 8'h81 : 8'h00));
            chk("t6_rise", 32'(r4), 32'((k == 6) ? 8'h81 : 8'h00));
            chk("t6_chg", 32'(c4), 32'(k == 6));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
